// File: rtl/sca_exec_window.sv
`default_nettype none
// ============================================================================
// Module   : sca_exec_window
// Purpose  : Execution-window controller for the side-channel capture top.
//            It turns a level start strobe into a gated operation window for
//            up to N_CH POLY_MAU channels, with a programmable window length,
//            repeat count and inter-run gap. The operand pair is frozen at the
//            accepted start and held for the whole capture.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            start, abort          - start strobe (level), abort request
//            cfg_work_cyc/gap_cyc  - cycles per run / idle cycles between runs
//            cfg_repeat            - runs per start
//            cfg_ch_mask           - channels enabled during WORK
//            a_in, b_in            - operands from the bus interface
//            a_out, b_out          - operands latched at the accepted start
//            ch_enable, trig, busy - window outputs (all registered)
//            done                  - one-cycle pulse after the final run
//            run_idx               - 0-based index of the current run
//            start_ovf             - sticky: start seen while busy
// Revision : 1.0 - initial release
// ============================================================================
module sca_exec_window #(
  parameter int N_CH   = 10,
  parameter int DATA_W = 24,
  parameter int CYC_W  = 8,
  parameter int RPT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CYC_W-1:0]  cfg_work_cyc,
  input  logic [CYC_W-1:0]  cfg_gap_cyc,
  input  logic [RPT_W-1:0]  cfg_repeat,
  input  logic [N_CH-1:0]   cfg_ch_mask,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [N_CH-1:0]   ch_enable,
  output logic              trig,
  output logic              busy,
  output logic              done,
  output logic [RPT_W-1:0]  run_idx,
  output logic              start_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WORK = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [CYC_W-1:0] c_cyc_one = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [RPT_W-1:0] c_rpt_one = {{(RPT_W-1){1'b0}}, 1'b1};

  state_t              state_q,     state_d;
  logic [CYC_W-1:0]    work_q,      work_d;
  logic [CYC_W-1:0]    gap_q,       gap_d;
  logic [RPT_W-1:0]    rpt_q,       rpt_d;
  logic [N_CH-1:0]     mask_q,      mask_d;
  logic [CYC_W-1:0]    cyc_cnt_q,   cyc_cnt_d;
  logic [RPT_W-1:0]    run_idx_q,   run_idx_d;
  logic [DATA_W-1:0]   a_q,         a_d;
  logic [DATA_W-1:0]   b_q,         b_d;
  logic [N_CH-1:0]     ch_enable_q, ch_enable_d;
  logic                trig_q,      trig_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                start_ovf_q, start_ovf_d;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    gap_d       = gap_q;
    rpt_d       = rpt_q;
    mask_d      = mask_q;
    cyc_cnt_d   = cyc_cnt_q;
    run_idx_d   = run_idx_q;
    a_d         = a_q;
    b_d         = b_q;
    start_ovf_d = start_ovf_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          // Zero length / zero repeat are promoted to 1 so the terminal
          // compares below (value - 1) never underflow.
          work_d      = (cfg_work_cyc == '0) ? c_cyc_one : cfg_work_cyc;
          rpt_d       = (cfg_repeat == '0) ? c_rpt_one : cfg_repeat;
          gap_d       = cfg_gap_cyc;
          mask_d      = cfg_ch_mask;
          a_d         = a_in;
          b_d         = b_in;
          cyc_cnt_d   = '0;
          run_idx_d   = '0;
          start_ovf_d = 1'b0;
          state_d     = ST_WORK;
        end
      end
      ST_WORK: begin
        if (cyc_cnt_q == work_q - c_cyc_one) begin
          cyc_cnt_d = '0;
          if (run_idx_q == rpt_q - c_rpt_one) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (gap_q == '0) begin
            run_idx_d = run_idx_q + c_rpt_one;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + c_cyc_one;
        end
      end
      ST_GAP: begin
        if (cyc_cnt_q == gap_q - c_cyc_one) begin
          cyc_cnt_d = '0;
          run_idx_d = run_idx_q + c_rpt_one;
          state_d   = ST_WORK;
        end else begin
          cyc_cnt_d = cyc_cnt_q + c_cyc_one;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && start) begin
      start_ovf_d = 1'b1;
    end

    // Abort wins over everything: drop to IDLE, suppress done, keep the
    // operands and run index for post-mortem inspection.
    if (abort) begin
      state_d   = ST_IDLE;
      done_d    = 1'b0;
      cyc_cnt_d = '0;
      run_idx_d = run_idx_q;
    end

    // Window outputs are decoded from the next state so they are registered
    // and line up with the state they describe.
    busy_d      = (state_d != ST_IDLE);
    trig_d      = (state_d == ST_WORK);
    ch_enable_d = (state_d == ST_WORK) ? mask_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      gap_q       <= '0;
      rpt_q       <= '0;
      mask_q      <= '0;
      cyc_cnt_q   <= '0;
      run_idx_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ch_enable_q <= '0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_ovf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      gap_q       <= gap_d;
      rpt_q       <= rpt_d;
      mask_q      <= mask_d;
      cyc_cnt_q   <= cyc_cnt_d;
      run_idx_q   <= run_idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ch_enable_q <= ch_enable_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_ovf_q <= start_ovf_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign ch_enable = ch_enable_q;
  assign trig      = trig_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign run_idx   = run_idx_q;
  assign start_ovf = start_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sca_exec_window.sv
`default_nettype none
// ============================================================================
// Module   : tb_sca_exec_window
// Purpose  : Directed self-checking bench for sca_exec_window. Cycle 0 is the
//            cycle in which start is sampled; outputs are sampled 1 time unit
//            after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sca_exec_window;
  localparam int N_CH   = 10;
  localparam int DATA_W = 24;
  localparam int CYC_W  = 8;
  localparam int RPT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CYC_W-1:0]  cfg_work_cyc = '0;
  logic [CYC_W-1:0]  cfg_gap_cyc = '0;
  logic [RPT_W-1:0]  cfg_repeat = '0;
  logic [N_CH-1:0]   cfg_ch_mask = '0;
  logic [DATA_W-1:0] a_in = '0;
  logic [DATA_W-1:0] b_in = '0;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [N_CH-1:0]   ch_enable;
  logic              trig;
  logic              busy;
  logic              done;
  logic [RPT_W-1:0]  run_idx;
  logic              start_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sca_exec_window #(
    .N_CH(N_CH), .DATA_W(DATA_W), .CYC_W(CYC_W), .RPT_W(RPT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_work_cyc(cfg_work_cyc), .cfg_gap_cyc(cfg_gap_cyc),
    .cfg_repeat(cfg_repeat), .cfg_ch_mask(cfg_ch_mask),
    .a_in(a_in), .b_in(b_in), .a_out(a_out), .b_out(b_out),
    .ch_enable(ch_enable), .trig(trig), .busy(busy), .done(done),
    .run_idx(run_idx), .start_ovf(start_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 0; returns in cycle 1 of the new window.
  task automatic kick(input logic [CYC_W-1:0] w, input logic [CYC_W-1:0] g,
                      input logic [RPT_W-1:0] r, input logic [N_CH-1:0] m,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    cfg_work_cyc = w;
    cfg_gap_cyc  = g;
    cfg_repeat   = r;
    cfg_ch_mask  = m;
    a_in         = a;
    b_in         = b;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({ch_enable, trig, busy, done, run_idx, start_ovf, a_out, b_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%h trig=%b busy=%b done=%b idx=%0d ovf=%b a=%h b=%h required all 0",
               ch_enable, trig, busy, done, run_idx, start_ovf, a_out, b_out);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy got %b required 0", busy);
    end
  endtask

  task automatic test_default();
    logic [N_CH-1:0] exp_en;
    kick(8'd6, 8'd0, 4'd1, 10'h3FF, 24'h123456, 24'hABCDEF);
    a_in = 24'h111111;
    b_in = 24'h222222;
    for (int c = 1; c <= 8; c++) begin
      exp_en = (c <= 6) ? 10'h3FF : 10'h000;
      checks++;
      if (ch_enable !== exp_en) begin
        errors++;
        $display("FAIL default_ch_enable cyc %0d got %h required %h", c, ch_enable, exp_en);
      end
      checks++;
      if (done !== (c == 7)) begin
        errors++;
        $display("FAIL default_done cyc %0d got %b required %b", c, done, (c == 7));
      end
      checks++;
      if (a_out !== 24'h123456 || b_out !== 24'hABCDEF) begin
        errors++;
        $display("FAIL default_operands cyc %0d got %h/%h required 123456/abcdef", c, a_out, b_out);
      end
      tick();
    end
  endtask

  task automatic test_repeat_gap();
    logic            in_work;
    logic [RPT_W-1:0] exp_idx;
    kick(8'd4, 8'd2, 4'd3, 10'h005, 24'h000001, 24'h000002);
    for (int c = 1; c <= 18; c++) begin
      in_work = (c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16);
      exp_idx = (c <= 6) ? 4'd0 : (c <= 12) ? 4'd1 : 4'd2;
      checks++;
      if (ch_enable !== (in_work ? 10'h005 : 10'h000) || trig !== in_work) begin
        errors++;
        $display("FAIL rpt_window cyc %0d got en=%h trig=%b required work=%b", c, ch_enable, trig, in_work);
      end
      checks++;
      if (busy !== (c <= 16) || done !== (c == 17)) begin
        errors++;
        $display("FAIL rpt_busy_done cyc %0d got busy=%b done=%b required %b/%b",
                 c, busy, done, (c <= 16), (c == 17));
      end
      if (c <= 16) begin
        checks++;
        if (run_idx !== exp_idx) begin
          errors++;
          $display("FAIL rpt_run_idx cyc %0d got %0d required %0d", c, run_idx, exp_idx);
        end
      end
      tick();
    end
  endtask

  task automatic test_zero_cfg();
    int               n;
    logic [RPT_W-1:0] last_idx;
    kick(8'd0, 8'd0, 4'd0, 10'h3FF, 24'h0000AA, 24'h0000BB);
    checks++;
    if (busy !== 1'b1 || trig !== 1'b1 || ch_enable !== 10'h3FF) begin
      errors++;
      $display("FAIL zero_window cyc 1 got busy=%b trig=%b en=%h required 1/1/3ff", busy, trig, ch_enable);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done cyc 2 got done=%b busy=%b required 1/0", done, busy);
    end
    // Start in the done cycle: all-ones length and repeat.
    kick(8'd255, 8'd0, 4'd15, 10'h3FF, 24'h0000CC, 24'h0000DD);
    cfg_work_cyc = 8'd5;
    cfg_repeat   = 4'd1;
    n = 0;
    last_idx = '0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      last_idx = run_idx;
      tick();
    end
    checks++;
    if (n != 3825) begin
      errors++;
      $display("FAIL max_busy_len got %0d required 3825", n);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL max_done got %b required 1", done);
    end
    checks++;
    if (last_idx !== 4'd14) begin
      errors++;
      $display("FAIL max_last_run_idx got %0d required 14", last_idx);
    end
    tick();
  endtask

  task automatic test_overrun();
    kick(8'd8, 8'd0, 4'd1, 10'h3FF, 24'h00F00D, 24'h00BEEF);
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (busy !== (c <= 8) || done !== (c == 9)) begin
        errors++;
        $display("FAIL ovr_busy_done cyc %0d got busy=%b done=%b required %b/%b",
                 c, busy, done, (c <= 8), (c == 9));
      end
      checks++;
      if (start_ovf !== (c >= 4)) begin
        errors++;
        $display("FAIL ovr_flag cyc %0d got %b required %b", c, start_ovf, (c >= 4));
      end
      checks++;
      if (a_out !== 24'h00F00D) begin
        errors++;
        $display("FAIL ovr_a_out cyc %0d got %h required 00f00d", c, a_out);
      end
      if (c == 3) begin
        start        = 1'b1;
        cfg_work_cyc = 8'd2;
        a_in         = 24'h777777;
      end
      if (c == 9) start = 1'b1;  // accepted in the done cycle
      tick();
      start = 1'b0;
    end
    // New window uses the later cfg_work_cyc = 2.
    checks++;
    if (start_ovf !== 1'b0 || busy !== 1'b1 || a_out !== 24'h777777) begin
      errors++;
      $display("FAIL ovr_restart got ovf=%b busy=%b a=%h required 0/1/777777", start_ovf, busy, a_out);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_new_len got done=%b busy=%b required 1/0", done, busy);
    end
    tick();
  endtask

  task automatic test_abort();
    kick(8'd10, 8'd0, 4'd2, 10'h3FF, 24'h0A0A0A, 24'h0B0B0B);
    for (int c = 1; c <= 8; c++) begin
      if (c <= 5) begin
        checks++;
        if (busy !== 1'b1 || ch_enable !== 10'h3FF) begin
          errors++;
          $display("FAIL abort_pre cyc %0d got busy=%b en=%h required 1/3ff", c, busy, ch_enable);
        end
      end else if (c <= 7) begin
        checks++;
        if ({ch_enable, trig, busy, done} !== '0) begin
          errors++;
          $display("FAIL abort_post cyc %0d got en=%h trig=%b busy=%b done=%b required all 0",
                   c, ch_enable, trig, busy, done);
        end
        checks++;
        if (a_out !== 24'h0A0A0A || run_idx !== 4'd0) begin
          errors++;
          $display("FAIL abort_hold cyc %0d got a=%h idx=%0d required 0a0a0a/0", c, a_out, run_idx);
        end
      end else begin
        checks++;
        if (busy !== 1'b1 || trig !== 1'b1 || a_out !== 24'h0C0C0C) begin
          errors++;
          $display("FAIL abort_restart cyc %0d got busy=%b trig=%b a=%h required 1/1/0c0c0c",
                   c, busy, trig, a_out);
        end
      end
      abort = (c == 5) || (c == 8);
      start = (c == 7);
      if (c == 7) a_in = 24'h0C0C0C;
      tick();
      abort = 1'b0;
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_second got busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_async_reset();
    kick(8'd4, 8'd5, 4'd2, 10'h3FF, 24'h5A5A5A, 24'hA5A5A5);
    for (int c = 1; c <= 5; c++) begin
      start = (c == 2);
      tick();
      start = 1'b0;
    end
    // Now in cycle 6, which is a GAP cycle.
    checks++;
    if (busy !== 1'b1 || trig !== 1'b0 || start_ovf !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got busy=%b trig=%b ovf=%b required 1/0/1", busy, trig, start_ovf);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ch_enable, trig, busy, done, run_idx, start_ovf, a_out, b_out} !== '0) begin
      errors++;
      $display("FAIL areset_clear got en=%h busy=%b ovf=%b a=%h b=%h required all 0",
               ch_enable, busy, start_ovf, a_out, b_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL areset_idle got busy=%b done=%b required 0/0", busy, done);
      end
    end
    kick(8'd3, 8'd0, 4'd1, 10'h0F0, 24'h000123, 24'h000456);
    checks++;
    if (busy !== 1'b1 || ch_enable !== 10'h0F0) begin
      errors++;
      $display("FAIL areset_restart got busy=%b en=%h required 1/0f0", busy, ch_enable);
    end
    tick();
    tick();
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL areset_done got %b required 1", done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_default();
    test_repeat_gap();
    test_zero_cfg();
    test_overrun();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout got running required finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
